// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi traceback back end.
//   NUM_STATES / STATE_W / DEC_W : trellis geometry for the K=4 (8-state) code
//   tb_state_e                   : traceback controller states
package viterbi_pkg;
  localparam int NUM_STATES = 8;
  localparam int STATE_W    = 3;
  localparam int DEC_W      = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    TRACE   = 2'd1,
    EMIT    = 2'd2
  } tb_state_e;
endpackage

// File: rtl/viterbi_traceback_tb_step.sv
// One combinational traceback step through the 8-state trellis.
//   cur_state  : state being traced back from
//   dec_bit    : survivor decision for cur_state at this step
//   prev_state : predecessor state
//   dec_out    : decoded bit recovered from this step
module tb_step
  import viterbi_pkg::*;
(
  input  logic [STATE_W-1:0] cur_state,
  input  logic               dec_bit,
  output logic [STATE_W-1:0] prev_state,
  output logic               dec_out
);
  // The decision bit supplies the oldest register bit the shift pushed out.
  assign prev_state = {dec_bit, cur_state[2:1]};
  assign dec_out    = cur_state[0] ^ prev_state[0] ^ prev_state[2];
endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: stores per-step survivor decision words for a frame,
// traces back from the final state on frame end and streams the decoded
// bits out in chronological order.
//   clk, rst                       : clock, synchronous active-high reset
//   dec_valid/dec_ready/dec_word   : decision word stream from ACS
//   dec_last, best_state           : frame end marker and final state
//   out_valid/out_ready/out_bit    : decoded bit stream
//   out_last                       : final decoded bit of the frame
//   overflow                       : pulse when a frame hits MAX_FRAME
// Optional build macro VITERBI_TB_ZERO_TAIL_EN: trace from state 0 and
// drop the 3 tail bits (frames of N<=3 produce no output).
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int MAX_FRAME = 64,
  parameter int CNT_W     = $clog2(MAX_FRAME+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [DEC_W-1:0]   dec_word,
  input  logic               dec_last,
  input  logic [STATE_W-1:0] best_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic               out_last,
  output logic               overflow
);
  localparam int AW = (MAX_FRAME > 1) ? $clog2(MAX_FRAME) : 1;

  tb_state_e          st;
  logic [CNT_W-1:0]   cnt, n_len, idx, oidx, last_idx;
  logic [STATE_W-1:0] cur_s, prev_s, start_s;
  logic [DEC_W-1:0]   mem [MAX_FRAME];
  logic [MAX_FRAME-1:0] bitbuf;
  logic [DEC_W-1:0]   rd_word;
  logic               step_bit, accept, at_cap, frame_end;

  assign dec_ready = (st == COLLECT);
  assign accept    = dec_valid && dec_ready;
  assign at_cap    = (cnt == CNT_W'(MAX_FRAME-1));
  assign frame_end = accept && (dec_last || at_cap);

`ifdef VITERBI_TB_ZERO_TAIL_EN
  assign start_s  = '0;
  assign last_idx = n_len - CNT_W'(4);
`else
  assign start_s  = best_state;
  assign last_idx = n_len - CNT_W'(1);
`endif

  assign rd_word = mem[idx[AW-1:0]];

  tb_step u_step (
    .cur_state  (cur_s),
    .dec_bit    (rd_word[cur_s]),
    .prev_state (prev_s),
    .dec_out    (step_bit)
  );

  // Storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (accept)        mem[cnt[AW-1:0]]    <= dec_word;
    if (st == TRACE)   bitbuf[idx[AW-1:0]] <= step_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= COLLECT;
      cnt       <= '0;
      n_len     <= '0;
      idx       <= '0;
      oidx      <= '0;
      cur_s     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (st)
        COLLECT: if (accept) begin
          cnt <= cnt + 1'b1;
          if (frame_end) begin
            // frame_end without dec_last can only be the forced cut at cap
            overflow <= !dec_last;
            n_len    <= cnt + 1'b1;
            idx      <= cnt;
            cur_s    <= start_s;
            oidx     <= '0;
`ifdef VITERBI_TB_ZERO_TAIL_EN
            // nothing survives tail removal: skip traceback entirely
            if (cnt < CNT_W'(3)) cnt <= '0;
            else                 st  <= TRACE;
`else
            st <= TRACE;
`endif
          end
        end
        TRACE: begin
          cur_s <= prev_s;
          if (idx == '0) st  <= EMIT;
          else           idx <= idx - 1'b1;
        end
        EMIT: begin
          // Registered output: refill when empty or when the held bit leaves.
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              cnt       <= '0;
              st        <= COLLECT;
            end else begin
              out_valid <= 1'b1;
              out_bit   <= bitbuf[oidx[AW-1:0]];
              out_last  <= (oidx == last_idx);
              oidx      <= oidx + 1'b1;
            end
          end
        end
        default: st <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_viterbi_traceback.sv
module tb_viterbi_traceback;
  localparam int MAXF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dec_valid = 1'b0, dec_last = 1'b0, out_ready = 1'b0;
  logic [7:0] dec_word = 8'h00;
  logic [2:0] best_state = 3'd0;
  logic       dec_ready, out_valid, out_bit, out_last, overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] frame_q[$];
  logic [1:0] sb[$];     // {bit, last}

  always #5 clk = ~clk;

  viterbi_traceback #(.MAX_FRAME(MAXF)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_word(dec_word),
    .dec_last(dec_last), .best_state(best_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_last(out_last), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Reference traceback over frame_q; pushes expected {bit,last} entries.
  task automatic expect_frame(input logic [2:0] best);
    int n, ne;
    logic [2:0] s, p;
    logic [7:0] w;
    logic [63:0] bb;
    n  = frame_q.size();
    bb = '0;
`ifdef VITERBI_TB_ZERO_TAIL_EN
    s  = 3'd0;
    ne = (n > 3) ? n - 3 : 0;
`else
    s  = best;
    ne = n;
`endif
    for (int i = n - 1; i >= 0; i--) begin
      w     = frame_q[i];
      p     = {w[s], s[2:1]};
      bb[i] = s[0] ^ p[0] ^ p[2];
      s     = p;
    end
    for (int i = 0; i < ne; i++) sb.push_back({bb[i], (i == ne - 1)});
  endtask

  task automatic send_frame(input logic [2:0] best, input bit use_last);
    int n, w;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      dec_valid  = 1'b1;
      dec_word   = frame_q[i];
      dec_last   = use_last && (i == n - 1);
      best_state = (i == n - 1) ? best : 3'($urandom_range(7));
      w = 0;
      while (!dec_ready && w < 50) begin tick; w++; end
      if (w >= 50) check("accept_timeout", {31'd0, dec_ready}, 32'd1);
      tick;
    end
    dec_valid = 1'b0;
    dec_last  = 1'b0;
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0; 2: 20-cycle stall first
  task automatic recv(input int mode, input int exp_lat);
    int c, k;
    logic held, hb, hl;
    logic [1:0] e;
    c = 0; k = 0; held = 1'b0; hb = 1'b0; hl = 1'b0;
    dec_valid = 1'b1; dec_word = 8'hFF; dec_last = 1'b1;  // must be ignored
    while (sb.size() > 0 && c < 400) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : (k >= 20);
      if (c == 1) check("ovf_clear", {31'd0, overflow}, 32'd0);
      check("ready_low", {31'd0, dec_ready}, 32'd0);
      if (held) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_bit",   {31'd0, out_bit},   {31'd0, hb});
        check("stall_last",  {31'd0, out_last},  {31'd0, hl});
      end
      if (out_valid) begin
        if (k == 0 && exp_lat >= 0) check("latency", c, exp_lat);
        held = !out_ready; hb = out_bit; hl = out_last;
        if (out_ready) begin
          e = sb.pop_front();
          check("out_bit",  {31'd0, out_bit},  {31'd0, e[1]});
          check("out_last", {31'd0, out_last}, {31'd0, e[0]});
        end
        k++;
      end else held = 1'b0;
      tick; c++;
    end
    dec_valid = 1'b0; dec_last = 1'b0; out_ready = 1'b0;
    check("drain", sb.size(), 0);
    check("ready_back", {31'd0, dec_ready}, 32'd1);
    check("valid_off",  {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    // reset state
    tick; tick;
    check("rst_ready",    {31'd0, dec_ready}, 32'd1);
    check("rst_valid",    {31'd0, out_valid}, 32'd0);
    check("rst_bit",      {31'd0, out_bit},   32'd0);
    check("rst_last",     {31'd0, out_last},  32'd0);
    check("rst_overflow", {31'd0, overflow},  32'd0);
    rst = 1'b0;
    tick;

    // known frame, hand-derived bits 1,0,1,1
    frame_q = '{8'h00, 8'h00, 8'h00, 8'h10};
`ifdef VITERBI_TB_ZERO_TAIL_EN
    expect_frame(3'd4);
`else
    sb.push_back(2'b10); sb.push_back(2'b00); sb.push_back(2'b10); sb.push_back(2'b11);
`endif
    send_frame(3'd4, 1'b1);
    check("ovf_none1", {31'd0, overflow}, 32'd0);
    recv(0, 5);

    // all-zero frame from state 0
    frame_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    expect_frame(3'd0);
    send_frame(3'd0, 1'b1);
    recv(0, 5);

    // same known frame with a stalling consumer
    frame_q = '{8'h00, 8'h00, 8'h00, 8'h10};
`ifdef VITERBI_TB_ZERO_TAIL_EN
    expect_frame(3'd4);
`else
    sb.push_back(2'b10); sb.push_back(2'b00); sb.push_back(2'b10); sb.push_back(2'b11);
`endif
    send_frame(3'd4, 1'b1);
    recv(1, 5);

    // forced termination at MAX_FRAME, long stall on output
    frame_q.delete();
    for (int i = 0; i < MAXF; i++) frame_q.push_back(8'($urandom));
    expect_frame(3'd5);
    send_frame(3'd5, 1'b0);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    recv(2, MAXF + 1);

    // random frames of every length, dec_last on the final beat
    for (int f = 1; f <= MAXF; f++) begin
      logic [2:0] b;
      frame_q.delete();
      for (int i = 0; i < f; i++) frame_q.push_back(8'($urandom));
      b = 3'($urandom_range(7));
      expect_frame(b);
      send_frame(b, 1'b1);
      check("ovf_none", {31'd0, overflow}, 32'd0);
      recv(f % 2, -1);
    end

    // reset in the middle of traceback
    frame_q = '{8'h5A, 8'h3C, 8'hA5, 8'hFF};
    send_frame(3'd6, 1'b1);
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, dec_ready}, 32'd1);

    // single-step frame after the reset
    frame_q = '{8'h00};
`ifdef VITERBI_TB_ZERO_TAIL_EN
    expect_frame(3'd1);
`else
    sb.push_back(2'b11);
`endif
    send_frame(3'd1, 1'b1);
    recv(0, 2);

    // six zero words: tail removal leaves three bits when enabled
    frame_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expect_frame(3'd7);
    send_frame(3'd7, 1'b1);
    recv(0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Back end of the Viterbi decoder for the 8-state (K=4) trellis, fed directly by the add-compare-select (ACS) stage.
- Stores one 8-bit survivor decision word per trellis step for a whole frame.
- On frame end, traces back from the final state, recovering one decoded bit per step.
- Emits the decoded bits in chronological order over a valid/ready stream.

Parameters:
- MAX_FRAME, 64: maximum trellis steps per frame (survivor memory depth).
- CNT_W, $clog2(MAX_FRAME+1): width of the step counter and index.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decision word valid (from ACS).
- dec_ready  out  1  block accepts a decision word; high only in COLLECT.
- dec_word  in  8  bit s is the survivor decision for state s at this step.
- dec_last  in  1  qualifies dec_word as the final step of the frame.
- best_state  in  3  minimum-metric state; sampled with the dec_last beat.
- out_valid  out  1  decoded bit valid.
- out_ready  in  1  consumer ready.
- out_bit  out  1  decoded bit.
- out_last  out  1  marks the final decoded bit of the frame.
- overflow  out  1  one-cycle pulse when a frame is force-terminated at MAX_FRAME.

Behaviour:
- Reset values:
  - state = COLLECT, step count = 0.
  - dec_ready = 1.
  - out_valid = out_bit = out_last = overflow = 0.
  - Memory contents are don't-care.
- Reset mid-operation: any in-flight frame is discarded and the block returns to COLLECT on the next cycle.
- Handshakes: transfer occurs on valid&&ready. out_bit and out_last are held stable while out_valid && !out_ready.
- COLLECT:
  - Each accepted dec_word is written to mem[cnt], then cnt increments.
  - Leave for TRACE on an accepted beat with dec_last=1: latch start = best_state and N = cnt+1.
  - Forced termination: an accepted beat at cnt = MAX_FRAME-1 with dec_last=0 behaves as dec_last=1 and pulses overflow in the following cycle.
- TRACE:
  - One step per cycle, index i from N-1 down to 0, with s = current state.
  - d = mem[i][s].
  - prev = {d, s[2:1]}.
  - decoded bit = s[0] ^ prev[0] ^ prev[2].
  - Write the decoded bit to bitbuf[i], then s <= prev.
  - Occupies exactly N cycles; dec_ready = 0.
- EMIT:
  - Presents bitbuf[0..N-1] in ascending order; out_last = 1 on index N-1.
  - After the last bit transfers, clear cnt and return to COLLECT with dec_ready = 1 in the next cycle.
- Latency: the first out_valid appears N+1 cycles after the dec_last beat is accepted.
- Boundaries:
  - N=1 frame: one TRACE cycle, then a single bit with out_last = 1.
  - dec_valid during TRACE/EMIT: ignored, because dec_ready is 0.
  - out_ready held low: EMIT stalls indefinitely with no loss.
- Memory: survivor memory is MAX_FRAME x 8 and bitbuf is MAX_FRAME x 1; both may infer as registers or RAM with a combinational read.

Optional Feature:
- Macro: VITERBI_TB_ZERO_TAIL_EN.
- When defined:
  - best_state is ignored; traceback starts from state 0, because the encoder is flushed with 3 zero tail bits.
  - EMIT outputs only bits 0..N-4, with out_last on N-4.
  - Frames with N<=3 produce no output and return straight to COLLECT.
- When undefined: start state is best_state and all N bits are emitted.

Decomposition:
- Shared package viterbi_pkg holds:
  - NUM_STATES=8, STATE_W=3, DEC_W=8.
  - The state enum {COLLECT, TRACE, EMIT}.
- Sub-module tb_step (combinational):
  - Inputs: cur_state[2:0], decision bit.
  - Outputs: prev_state[2:0], decoded bit.
  - Implements the two formulas above; unit-testable exhaustively over 16 cases.

Test Plan:
- Frame of words 0x00,0x00,0x00,0x10 with best_state=4 and dec_last on the 4th word -> out_bit sequence 1,0,1,1 with out_last on the 4th bit; the first out_valid appears 5 cycles after the last accept.
- 4 words of 0x00 with best_state=0 -> bits 0,0,0,0; dec_ready stays low from the dec_last beat until the final out transfer completes.
- MAX_FRAME=8, 8 beats with dec_last never asserted -> overflow pulses once; 8 bits are emitted with out_last on the 8th.
- out_ready toggling 1,0,0,1,... during EMIT of the first scenario -> bits unchanged across stalls; sequence still 1,0,1,1.
- rst asserted mid-TRACE -> next cycle: out_valid=0, dec_ready=1; a subsequent 1-word frame (0x00, best_state=1) yields a single bit 1 with out_last=1.
- With VITERBI_TB_ZERO_TAIL_EN and 6 words of 0x00 -> start state 0, exactly 3 bits 0,0,0 emitted with out_last on the 3rd.
